// File: rtl/exe_pkg.sv
// Shared types for the sequential exe unit: opcodes, FSM states and status bit positions.
package exe_pkg;

  typedef enum logic [2:0] {
    OP_CONV  = 3'd0,
    OP_SHR   = 3'd1,
    OP_LT    = 3'd2,
    OP_BFLIP = 3'd3,
    OP_MUL   = 3'd4,
    OP_ADD   = 3'd5,
    OP_SUB   = 3'd6,
    OP_BAD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int STAT_ERR  = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_ONES = 2;
  localparam int STAT_PAR  = 3;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative signed shift-add multiplier: one partial product per cycle, M cycles total,
// the MSB partial product subtracted because B is two's complement.
module exe_mul_iter #(
  parameter int M = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic signed [M-1:0]   i_a,
  input  logic signed [M-1:0]   i_b,
  output logic                  o_done,
  output logic signed [2*M-1:0] o_prod
);

  localparam int CW = $clog2(M + 1);

  logic signed [2*M-1:0] a_ext;
  logic signed [2*M-1:0] mcand;
  logic        [M-1:0]   b_u;
  logic        [M-1:0]   mplier;
  logic        [CW-1:0]  cnt;
  logic                  busy;

  assign a_ext = {{M{i_a[M-1]}}, i_a};
  assign b_u   = i_b;

  // Bit 0 is consumed in the start cycle, bits 1..M-1 on the following M-1 cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy   <= 1'b0;
      o_done <= 1'b0;
      cnt    <= '0;
      o_prod <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (i_start) begin
      o_prod <= b_u[0] ? a_ext : '0;
      mcand  <= a_ext <<< 1;
      mplier <= b_u >> 1;
      cnt    <= CW'(1);
      busy   <= 1'b1;
      o_done <= 1'b0;
    end else if (busy) begin
      if (mplier[0])
        o_prod <= (cnt == CW'(M - 1)) ? o_prod - mcand : o_prod + mcand;
      mcand  <= mcand <<< 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CW'(M - 1)) begin
        busy   <= 1'b0;
        o_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/exe_unit_seq.sv
// Sequential exe unit: single-cycle ALU ops, iterative SHR/MUL under an IDLE/CALC/DONE FSM,
// valid/ready on both sides with result/status held in DONE until popped.
module exe_unit_seq
  import exe_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [N-1:0]        i_oper,
  input  logic signed [M-1:0] i_argA,
  input  logic signed [M-1:0] i_argB,
  output logic                o_valid,
  input  logic                i_ready,
  output logic signed [M-1:0] o_result,
  output logic [3:0]          o_status
);

  localparam int                CW       = $clog2(M + 1);
  localparam logic [N-1:0]      LOW_MASK = N'(7);
  localparam logic signed [M-1:0] A_MIN  = {1'b1, {(M-1){1'b0}}};

  function automatic logic [3:0] status_f(input logic [M-1:0] r, input logic err,
                                          input logic ovf);
    logic [3:0] s;
    s            = '0;
    s[STAT_ERR]  = err;
    s[STAT_OVF]  = ovf;
    s[STAT_ONES] = &r;
    s[STAT_PAR]  = ^r;
    return s;
  endfunction

  state_e                state;
  op_e                   op_c;
  logic                  accept, upper_bad, go_calc, err_c, ovf_c, is_mul_c;
  logic signed [M-1:0]   res_c, sum_c, dif_c, neg_a;
  logic        [CW-1:0]  lim_c, lim_q, cnt;
  logic signed [M-1:0]   shr_q;
  logic                  is_mul_q;
  logic                  mul_start, mul_done, mul_fit;
  logic signed [2*M-1:0] mul_prod;

  assign accept    = i_valid && o_ready;
  assign upper_bad = |(i_oper & ~LOW_MASK);
  assign op_c      = op_e'(i_oper[2:0]);
  assign is_mul_c  = !upper_bad && (op_c == OP_MUL);
  assign mul_start = accept && is_mul_c;
  assign sum_c     = i_argA + i_argB;
  assign dif_c     = i_argA - i_argB;
  assign neg_a     = -i_argA;
  assign lim_c     = (i_argB >= M) ? CW'(M) : CW'(i_argB);
  assign mul_fit   = (&mul_prod[2*M-1:M-1]) | ~(|mul_prod[2*M-1:M-1]);

  always_comb begin
    res_c   = '0;
    err_c   = 1'b0;
    ovf_c   = 1'b0;
    go_calc = 1'b0;
    if (upper_bad) begin
      err_c = 1'b1;
    end else begin
      case (op_c)
        OP_CONV: begin
          if (i_argA == A_MIN)  ovf_c = 1'b1;
          else if (i_argA < 0)  res_c = {1'b1, neg_a[M-2:0]};
          else                  res_c = i_argA;
        end
        OP_SHR: begin
          if (i_argB < 0)       err_c = 1'b1;
          else if (i_argB == 0) res_c = i_argA;
          else                  go_calc = 1'b1;
        end
        OP_LT:    res_c = {{(M-1){1'b0}}, (i_argA < i_argB)};
        OP_BFLIP: begin
          if (i_argB < 0 || i_argB >= M) err_c = 1'b1;
          else res_c = i_argA ^ (M'(1) << i_argB);
        end
        OP_MUL:   go_calc = 1'b1;
        OP_ADD: begin
          res_c = sum_c;
          ovf_c = (i_argA[M-1] == i_argB[M-1]) && (sum_c[M-1] != i_argA[M-1]);
        end
        OP_SUB: begin
          res_c = dif_c;
          ovf_c = (i_argA[M-1] != i_argB[M-1]) && (dif_c[M-1] != i_argA[M-1]);
        end
        OP_BAD:   err_c = 1'b1;
      endcase
    end
  end

  // Operand/shift datapath: captured on accept, shifted one bit per CALC cycle.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      shr_q    <= i_argA;
      lim_q    <= lim_c;
      is_mul_q <= is_mul_c;
    end else if (state == ST_CALC) begin
      shr_q <= shr_q >>> 1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_status <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            o_ready <= 1'b0;
            cnt     <= '0;
            if (go_calc) begin
              state <= ST_CALC;
            end else begin
              state    <= ST_DONE;
              o_valid  <= 1'b1;
              o_result <= res_c;
              o_status <= status_f(res_c, err_c, ovf_c);
            end
          end
        end
        ST_CALC: begin
          if (is_mul_q) begin
            if (mul_done) begin
              state    <= ST_DONE;
              o_valid  <= 1'b1;
              o_result <= mul_prod[M-1:0];
              o_status <= status_f(mul_prod[M-1:0], 1'b0, !mul_fit);
            end
          end else if (cnt == lim_q - 1'b1) begin
            // Last shift is folded into the result write; counter parks at its limit.
            state    <= ST_DONE;
            o_valid  <= 1'b1;
            o_result <= shr_q >>> 1;
            o_status <= status_f(shr_q >>> 1, 1'b0, 1'b0);
            cnt      <= lim_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  exe_mul_iter #(.M(M)) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mul_start),
    .i_a     (i_argA),
    .i_b     (i_argB),
    .o_done  (mul_done),
    .o_prod  (mul_prod)
  );

endmodule

// File: tb/tb_exe_unit_seq.sv
// Directed bench for exe_unit_seq (M=8, N=3) with an arithmetic reference model and literal pins.
module tb_exe_unit_seq;

  logic       i_clk, i_rst, i_valid, o_ready, o_valid, i_ready;
  logic [2:0] i_oper;
  logic [7:0] i_argA, i_argB, o_result;
  logic [3:0] o_status;

  int   npass = 0;
  int   ntot  = 0;
  logic chk_en = 1'b0;
  logic [7:0] exp_res;
  logic [3:0] exp_stat;

  exe_unit_seq #(.M(8), .N(3)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_oper   (i_oper),
    .i_argA   (i_argA),
    .i_argB   (i_argB),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_status (o_status)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input int act, input int req);
    ntot++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  // Reference: outputs computed directly from the operation's arithmetic meaning.
  function automatic void model(input logic [2:0] op, input logic signed [7:0] a,
                                input logic signed [7:0] b, output logic [7:0] r,
                                output logic [3:0] st, output int lat);
    int ia, ib, p, s;
    bit err, ovf;
    ia = a; ib = b; err = 0; ovf = 0; r = 8'h00; lat = 1;
    case (op)
      3'd0: if (ia == -128) ovf = 1;
            else if (ia < 0) r = 8'h80 | 8'(-ia);
            else r = 8'(ia);
      3'd1: if (ib < 0) err = 1;
            else begin
              s = (ib > 8) ? 8 : ib;
              p = ia >>> s;
              r = 8'(p);
              lat = 1 + s;
            end
      3'd2: r = (ia < ib) ? 8'd1 : 8'd0;
      3'd3: if (ib < 0 || ib > 7) err = 1;
            else r = 8'(ia ^ (1 << ib));
      3'd4: begin p = ia * ib; r = 8'(p); ovf = (p > 127) || (p < -128); lat = 9; end
      3'd5: begin p = ia + ib; r = 8'(p); ovf = (p > 127) || (p < -128); end
      3'd6: begin p = ia - ib; r = 8'(p); ovf = (p > 127) || (p < -128); end
      default: err = 1;
    endcase
    st = {^r, &r, ovf, err};
  endfunction

  always @(negedge i_clk) begin
    if (chk_en && o_valid) begin
      check("res_vs_model", o_result, exp_res);
      check("stat_vs_model", o_status, exp_stat);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] lres, input logic [3:0] lst, input int llat,
                        input int hold);
    logic [7:0] mr;
    logic [3:0] ms;
    int ml, lat;
    model(op, a, b, mr, ms, ml);
    @(negedge i_clk);
    check("rdy_idle", o_ready, 1);
    exp_res = mr; exp_stat = ms;
    i_oper = op; i_argA = a; i_argB = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk_en  = 1'b1;
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
    check("latency", lat, ml);
    check("lit_latency", lat, llat);
    check("lit_result", o_result, lres);
    check("lit_status", o_status, lst);
    for (int k = 0; k < hold; k++) begin
      @(negedge i_clk);
      i_valid = 1'b1; i_oper = 3'd5; i_argA = 8'h01; i_argB = 8'h01;
      check("hold_ready", o_ready, 0);
      check("hold_valid", o_valid, 1);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk_en  = 1'b0;
    check("pop_valid", o_valid, 0);
    check("pop_ready", o_ready, 1);
  endtask

  initial begin
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_oper = '0; i_argA = '0; i_argB = '0;
    #2 i_rst = 1'b1;
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_status", o_status, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b0;

    //     op    A      B      res    stat  lat hold
    run_op(3'd0, 8'h78, 8'h00, 8'h78, 4'h0, 1, 0);
    run_op(3'd0, 8'hF8, 8'h00, 8'h88, 4'h0, 1, 0);
    run_op(3'd0, 8'h80, 8'h00, 8'h00, 4'h2, 1, 0);
    run_op(3'd1, 8'hBC, 8'h02, 8'hEF, 4'h8, 3, 0);
    run_op(3'd1, 8'hBC, 8'hFE, 8'h00, 4'h1, 1, 0);
    run_op(3'd1, 8'hBC, 8'h00, 8'hBC, 4'h8, 1, 0);
    run_op(3'd1, 8'h80, 8'h09, 8'hFF, 4'h4, 9, 0);
    run_op(3'd3, 8'hFE, 8'h00, 8'hFF, 4'h4, 1, 0);
    run_op(3'd3, 8'h3C, 8'h08, 8'h00, 4'h1, 1, 0);
    run_op(3'd4, 8'h05, 8'hFD, 8'hF1, 4'h8, 9, 0);
    run_op(3'd4, 8'h10, 8'h10, 8'h00, 4'h2, 9, 0);
    run_op(3'd2, 8'hDC, 8'h3C, 8'h01, 4'h8, 1, 5);
    run_op(3'd6, 8'h80, 8'h01, 8'h7F, 4'hA, 1, 0);
    run_op(3'd7, 8'h12, 8'h34, 8'h00, 4'h1, 1, 0);

    // Reset during the 4th CALC cycle of a multiply.
    @(negedge i_clk);
    i_oper = 3'd4; i_argA = 8'h05; i_argB = 8'hFD; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    check("midrst_result", o_result, 0);
    check("midrst_status", o_status, 0);
    @(negedge i_clk) i_rst = 1'b0;

    run_op(3'd5, 8'h7F, 8'h01, 8'h80, 4'hA, 1, 0);
    run_op(3'd4, 8'hFF, 8'hFF, 8'h01, 4'h8, 9, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
